// File: rtl/pkg_digit.sv
// Shared widths, default timing parameters and the update-decision helper
// for the single decimal digit counter.
package pkg_digit;

    localparam int DIGIT_W        = 4;
    localparam int DEF_MAX_DIGIT  = 9;
    localparam int DEF_DEB_CYCLES = 1_000_000;
    localparam int DEF_AUTO_DIV   = 100_000_000;

    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_INC,
        UPD_DEC
    } upd_e;

    // Opposing requests cancel; a single request wins.
    function automatic upd_e decode_upd(input logic inc, input logic dec);
        if (inc && !dec) return UPD_INC;
        if (dec && !inc) return UPD_DEC;
        return UPD_HOLD;
    endfunction

endpackage

// File: rtl/m_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted press.
module m_debounce
    import pkg_digit::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int             CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             s_q;
    logic             db_q, db_d;
    logic             db_dly_q;
    logic [CNT_W-1:0] dc_q, dc_d;

    // NOTE: defaults are assigned first so every path drives every output; a missed branch would otherwise infer a latch.
    always_comb begin
        db_d = db_q;
        dc_d = dc_q;
        if (s_q == db_q) begin
            dc_d = '0;
        end else if (dc_q == CNT_LAST) begin
            db_d = s_q;
            dc_d = '0;
        end else begin
            dc_d = dc_q + CNT_W'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            dc_q     <= '0;
        end else begin
            sync1_q  <= raw;
            s_q      <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            dc_q     <= dc_d;
        end
    end

    assign level = db_q;
    assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/m_digit_cnt.sv
// Decimal digit register driven by debounced up/down buttons and an optional
// auto-run prescaler; emits carry/borrow pulses for cascading.
module m_digit_cnt
    import pkg_digit::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int AUTO_DIV   = DEF_AUTO_DIV,
    parameter int MAX_DIGIT  = DEF_MAX_DIGIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_dn,
    input  logic               auto_en,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry,
    output logic               borrow
);

    localparam int                 PRE_W    = $clog2(AUTO_DIV);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(AUTO_DIV - 1);
    localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_DIGIT);

    logic [1:0]         deb_level_unused;
    logic               up_press, dn_press;
    logic               tick;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               carry_q, carry_d;
    logic               borrow_q, borrow_d;

    m_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_up),
        .level (deb_level_unused[0]),
        .press (up_press)
    );

    m_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_dn),
        .level (deb_level_unused[1]),
        .press (dn_press)
    );

    // Disabling parks the prescaler at zero, so re-enabling waits a full period.
    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (!auto_en || tick) pre_d = '0;
    end

    always_comb begin
        digit_d  = digit_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        unique case (decode_upd(up_press | tick, dn_press))
            UPD_INC: begin
                if (digit_q == MAX_D) begin
                    digit_d = '0;
                    carry_d = 1'b1;
                end else begin
                    digit_d = digit_q + DIGIT_W'(1);
                end
            end
            UPD_DEC: begin
                if (digit_q == '0) begin
                    digit_d  = MAX_D;
                    borrow_d = 1'b1;
                end else begin
                    digit_d = digit_q - DIGIT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            digit_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            digit_q  <= digit_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign digit  = digit_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_m_digit_cnt.sv
// Scoreboard bench for m_digit_cnt: a cycle-level reference model predicts
// every digit/carry/borrow event, a negedge monitor pops and compares.
module tb_m_digit_cnt;

    localparam int DEB  = 4;
    localparam int ADIV = 8;
    localparam int MAXD = 9;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       btn_up  = 1'b0;
    logic       btn_dn  = 1'b0;
    logic       auto_en = 1'b0;
    logic [3:0] digit;
    logic       carry, borrow;

    m_digit_cnt #(.DEB_CYCLES(DEB), .AUTO_DIV(ADIV), .MAX_DIGIT(MAXD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .auto_en (auto_en),
        .digit   (digit),
        .carry   (carry),
        .borrow  (borrow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int dig;
        bit c;
        bit b;
    } ev_t;
    ev_t exp_q[$];

    int mon_last   = 0;
    int carry_cnt  = 0;
    int borrow_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A button level is accepted once the synchronized input (raw delayed by
    // two edges) has disagreed with it on DEB consecutive edges.
    typedef struct {
        bit r1;
        bit r2;
        bit lvl;
        bit prev;
        int run;
    } btn_m_t;

    btn_m_t mu, md;
    int     m_digit = 0;
    int     m_run   = 0;
    bit     m_pu, m_pd, m_tick, m_c, m_b;
    int     m_nd;

    function automatic btn_m_t deb_step(input btn_m_t b, input bit raw);
        btn_m_t n = b;
        n.prev = b.lvl;
        if (b.r2 != b.lvl) begin
            n.run = b.run + 1;
            if (n.run == DEB) begin
                n.lvl = b.r2;
                n.run = 0;
            end
        end else begin
            n.run = 0;
        end
        n.r2 = b.r1;
        n.r1 = raw;
        return n;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            mu      = '{default: 0};
            md      = '{default: 0};
            m_digit = 0;
            m_run   = 0;
        end else begin
            m_pu   = mu.lvl && !mu.prev;
            m_pd   = md.lvl && !md.prev;
            // m_run = enabled edges since enable or since the last tick
            m_tick = (m_run == ADIV - 1);
            m_nd   = m_digit;
            m_c    = 1'b0;
            m_b    = 1'b0;
            if ((m_pu || m_tick) && !m_pd) begin
                m_nd = (m_digit + 1) % (MAXD + 1);
                m_c  = (m_digit == MAXD);
            end else if (m_pd && !(m_pu || m_tick)) begin
                m_nd = (m_digit + MAXD) % (MAXD + 1);
                m_b  = (m_digit == 0);
            end
            if (m_nd != m_digit || m_c || m_b)
                exp_q.push_back('{cyc: cyc, dig: m_nd, c: m_c, b: m_b});
            m_digit = m_nd;
            m_run   = (auto_en && !m_tick) ? m_run + 1 : 0;
            mu      = deb_step(mu, btn_up);
            md      = deb_step(md, btn_dn);
        end
    end

    // ---------------- monitor ----------------
    ev_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("missed_event_digit", int'(digit), e.dig);
            end
            if (carry)  carry_cnt++;
            if (borrow) borrow_cnt++;
            if (carry || borrow)
                check("carry_borrow_exclusive", int'(carry & borrow), 0);
            if (int'(digit) != mon_last || carry || borrow) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle",  cyc,           e.cyc);
                    check("event_digit",  int'(digit),   e.dig);
                    check("event_carry",  int'(carry),   int'(e.c));
                    check("event_borrow", int'(borrow),  int'(e.b));
                end
                mon_last = int'(digit);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_sync();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        mon_last   = 0;
        carry_cnt  = 0;
        borrow_cnt = 0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic press(input bit up);
        if (up) btn_up = 1'b1; else btn_dn = 1'b1;
        cycles(7);
        if (up) btn_up = 1'b0; else btn_dn = 1'b0;
        cycles(7);
    endtask

    // Returns the edge number after which digit first differs, or -1.
    task automatic wait_change(input int limit, output int at);
        int start;
        start = int'(digit);
        at    = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (int'(digit) != start) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int k, at, e0;

    initial begin
        // Reset state
        cycles(3);
        check("rst_digit",  int'(digit),  0);
        check("rst_carry",  int'(carry),  0);
        check("rst_borrow", int'(borrow), 0);
        check("rst_dc_up",  int'(dut.u_deb_up.dc_q), 0);
        rst_n = 1'b1;
        cycles(2);

        // 1: held button, latency and single pulse. The button is launched
        //    in the cycle after edge k, so the synchronizer captures it next.
        btn_up = 1'b1;
        k = cyc;
        wait_change(20, at);
        check("t1_latency", at, k + DEB + 3);
        check("t1_digit",   int'(digit), 1);
        cycles(20 - (cyc - k));
        btn_up = 1'b0;
        cycles(15);
        check("t1_hold_release", int'(digit), 1);

        // 2: glitch one cycle shorter than the debounce window
        reset_sync();
        cycles(2);
        btn_up = 1'b1;
        cycles(DEB - 1);
        btn_up = 1'b0;
        cycles(12);
        check("t2_digit",  int'(digit), 0);
        check("t2_dc_up",  int'(dut.u_deb_up.dc_q), 0);

        // 3: ten up presses with carry, then one down press with borrow
        reset_sync();
        cycles(2);
        for (int i = 1; i <= 10; i++) begin
            press(1'b1);
            check("t3_up_digit", int'(digit), i % (MAXD + 1));
        end
        check("t3_carry_pulses", carry_cnt, 1);
        press(1'b0);
        check("t3_dn_digit",      int'(digit), MAXD);
        check("t3_borrow_pulses", borrow_cnt, 1);

        // 4: auto-run ticks, gap while disabled, restart after re-enable
        reset_sync();
        cycles(2);
        auto_en = 1'b1;
        e0 = cyc;
        wait_change(12, at);
        check("t4_tick1", at, e0 + ADIV);
        wait_change(12, at);
        check("t4_tick2", at, e0 + 2 * ADIV);
        cycles(e0 + 20 - cyc);
        auto_en = 1'b0;
        cycles(10);
        check("t4_no_tick24", int'(digit), 2);
        auto_en = 1'b1;
        e0 = cyc;
        wait_change(12, at);
        check("t4_reenable", at, e0 + ADIV);
        check("t4_digit",    int'(digit), 3);
        auto_en = 1'b0;
        cycles(4);

        // 5: simultaneous up/down cancel; up press colliding with a tick
        reset_sync();
        cycles(2);
        btn_up = 1'b1;
        btn_dn = 1'b1;
        cycles(10);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cycles(10);
        check("t5_cancel_digit", int'(digit), 0);
        check("t5_cancel_cb",    carry_cnt + borrow_cnt, 0);
        auto_en = 1'b1;
        e0 = cyc;
        cycles(1);
        btn_up = 1'b1;
        wait_change(12, at);
        check("t5_coincide_cycle", at, e0 + ADIV);
        check("t5_coincide_digit", int'(digit), 1);
        auto_en = 1'b0;
        btn_up  = 1'b0;
        cycles(12);

        // 6: asynchronous reset mid-debounce at digit 6
        reset_sync();
        cycles(2);
        for (int i = 0; i < 6; i++) press(1'b1);
        check("t6_pre_digit", int'(digit), 6);
        btn_up = 1'b1;
        cycles(4);
        check("t6_half_counted", int'(dut.u_deb_up.dc_q), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_digit",  int'(digit),  0);
        check("t6_async_carry",  int'(carry),  0);
        check("t6_async_borrow", int'(borrow), 0);
        check("t6_async_dc",     int'(dut.u_deb_up.dc_q), 0);
        exp_q.delete();
        mon_last = 0;
        @(negedge clk);
        rst_n = 1'b1;
        k = cyc;
        wait_change(20, at);
        check("t6_relatency", at, k + DEB + 3);
        btn_up = 1'b0;
        cycles(10);

        // 7: random buttons and auto-run against the model
        reset_sync();
        cycles(2);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0)  btn_up  = ~btn_up;
            if ($urandom_range(0, 5) == 0)  btn_dn  = ~btn_dn;
            if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
        end
        btn_up  = 1'b0;
        btn_dn  = 1'b0;
        auto_en = 1'b0;
        cycles(20);
        check("t7_final_digit", int'(digit), m_digit);
        check("queue_drained",  exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
